cga_line_doubler: RTL and testbench

//  Scan doubler downstream of the CGA pixel pipeline. Stores each incoming line of
//  4-bit IRGB pixels (written at pix_ce rate) in a ping-pong line buffer. Replays the

---
 rtl/cga_line_doubler.sv | 171 +++++++++++++++++
 tb/tb_cga_line_doubler.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/cga_line_doubler.sv
// cga_line_doubler: CGA scan doubler.
// Ping-pong line buffer, replays each line twice at clk rate.
module cga_line_doubler #(
  parameter int ADDR_W  = 10,
  parameter int LEN_W   = 12,
  parameter int HSYNC_W = 48
) (
  input  logic       clk,
  input  logic       reset_l,
  input  logic       pix_ce,
  input  logic       line_reset,
  input  logic [3:0] video,
  output logic       dbl_hsync,
  output logic [3:0] dbl_video,
  output logic       dbl_half,
  output logic       line_ovf
);

  localparam logic [ADDR_W:0] FULL =
    {1'b1, {ADDR_W{1'b0}}};
  localparam logic [LEN_W-1:0] LMAX = '1;
  localparam logic [LEN_W-1:0] HS_END =
    LEN_W'(HSYNC_W);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LINE0 = 2'd1;
  localparam logic [1:0] LINE1 = 2'd2;

  logic [3:0] mem [0:(2**(ADDR_W+1))-1];

  logic              bank;
  logic [ADDR_W:0]   wr_cnt;
  logic [ADDR_W:0]   pix_cnt;
  logic              ovf_seen;
  logic [LEN_W-1:0]  clk_cnt;
  logic [LEN_W-1:0]  len;
  logic [LEN_W-1:0]  half_len;
  logic [LEN_W-1:0]  rd_cnt;
  logic [1:0]        state;
  logic              valid;
  logic              seen_lr;

  logic              wr_room;
  logic              we;
  logic              w_bank;
  logic [ADDR_W-1:0] w_addr;
  logic [ADDR_W-1:0] r_addr;
  logic [3:0]        rd_data;

  logic              s1_act;
  logic              s1_blank;
  logic              s1_hs;
  logic              s1_half;

  // wr_cnt carries one extra bit so the
  // last address is writable before drops
  assign wr_room  = wr_cnt < FULL;
  assign we       = pix_ce & (line_reset | wr_room);
  assign w_bank   = line_reset ? ~bank : bank;
  assign w_addr   = line_reset ? '0
                  : wr_cnt[ADDR_W-1:0];
  assign r_addr   = rd_cnt[ADDR_W-1:0];
  assign half_len = len >> 1;

  // Line buffer: one write, one registered read
  always_ff @(posedge clk) begin
    if (we)
      mem[{w_bank, w_addr}] <= video;
    rd_data <= mem[{~bank, r_addr}];
  end

  // Write side: bank swap, counts, overflow
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      bank     <= 1'b0;
      wr_cnt   <= '0;
      pix_cnt  <= '0;
      ovf_seen <= 1'b0;
      line_ovf <= 1'b0;
      clk_cnt  <= '0;
      len      <= '0;
    end else begin
      line_ovf <= 1'b0;
      if (line_reset) begin
        bank     <= ~bank;
        wr_cnt   <= {{ADDR_W{1'b0}}, pix_ce};
        pix_cnt  <= wr_cnt;
        len      <= clk_cnt;
        clk_cnt  <= LEN_W'(1);
        ovf_seen <= 1'b0;
      end else begin
        if (clk_cnt != LMAX)
          clk_cnt <= clk_cnt + 1'b1;
        if (pix_ce) begin
          if (wr_room) begin
            wr_cnt <= wr_cnt + 1'b1;
          end else if (!ovf_seen) begin
            line_ovf <= 1'b1;
            ovf_seen <= 1'b1;
          end
        end
      end
    end
  end

  // Read side: two-line fill, then two halves
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state   <= IDLE;
      valid   <= 1'b0;
      seen_lr <= 1'b0;
      rd_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (line_reset) begin
            if (seen_lr) begin
              state  <= LINE0;
              valid  <= 1'b1;
              rd_cnt <= '0;
            end else begin
              seen_lr <= 1'b1;
            end
          end
        end
        LINE0: begin
          if (line_reset) begin
            rd_cnt <= '0;
          end else if (rd_cnt == half_len - 1'b1) begin
            state  <= LINE1;
            rd_cnt <= '0;
          end else if (rd_cnt != LMAX) begin
            rd_cnt <= rd_cnt + 1'b1;
          end
        end
        LINE1: begin
          if (line_reset) begin
            state  <= LINE0;
            rd_cnt <= '0;
          end else if (rd_cnt != LMAX) begin
            rd_cnt <= rd_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Align sync/half/blank with RAM latency
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      s1_act    <= 1'b0;
      s1_blank  <= 1'b1;
      s1_hs     <= 1'b0;
      s1_half   <= 1'b0;
      dbl_video <= 4'h0;
      dbl_hsync <= 1'b0;
      dbl_half  <= 1'b0;
    end else begin
      s1_act    <= valid;
      s1_blank  <= rd_cnt >= LEN_W'(pix_cnt);
      s1_hs     <= valid & (rd_cnt < HS_END);
      s1_half   <= valid & (state == LINE1);
      dbl_video <= (s1_act & ~s1_blank)
                 ? rd_data : 4'h0;
      dbl_hsync <= s1_hs;
      dbl_half  <= s1_half;
    end
  end

endmodule

// File: tb/tb_cga_line_doubler.sv
// tb_cga_line_doubler: random lines vs a
// line-level model of the doubled output.
module tb_cga_line_doubler;

  logic       clk = 1'b0;
  logic       reset_l = 1'b0;
  logic       pix_ce = 1'b0;
  logic       line_reset = 1'b0;
  logic [3:0] video = 4'h0;
  logic       dbl_hsync;
  logic [3:0] dbl_video;
  logic       dbl_half;
  logic       line_ovf;

  cga_line_doubler #(
    .ADDR_W(10), .LEN_W(12), .HSYNC_W(48)
  ) dut (
    .clk(clk),
    .reset_l(reset_l),
    .pix_ce(pix_ce),
    .line_reset(line_reset),
    .video(video),
    .dbl_hsync(dbl_hsync),
    .dbl_video(dbl_video),
    .dbl_half(dbl_half),
    .line_ovf(line_ovf)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errs = 0;
  int cyc = 0;

  // model: line history in plain arrays
  int nlr;
  bit started;
  int el;
  int cur_q[$];
  bit ovf_done;
  int rep_pix[1024];
  int rep_cnt;
  int rep_half;
  int es_hs, es_half, es_vid;
  int eo_hs, eo_half, eo_vid;
  int e_ovf;

  task automatic check(string tag, int got,
                       int exp);
    vectors++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d",
               tag, cyc, got, exp);
    end
  endtask

  function automatic void mdl_reset();
    nlr = 0; started = 0; el = 0;
    cur_q.delete(); ovf_done = 0;
    rep_cnt = 0; rep_half = 0;
    es_hs = 0; es_half = 0; es_vid = 0;
    eo_hs = 0; eo_half = 0; eo_vid = 0;
    e_ovf = 0;
  endfunction

  task automatic step(input bit lr, input bit pc,
                      input int vid);
    int rd, h, hs, v, l;
    @(negedge clk);
    line_reset = lr;
    pix_ce = pc;
    video = 4'(vid);
    @(posedge clk);
    cyc++;
    hs = 0; h = 0; v = 0;
    if (started) begin
      if (el < rep_half) begin
        rd = el;
      end else begin
        h = 1;
        rd = el - rep_half;
        if (rd > 4095) rd = 4095;
      end
      hs = (rd < 48) ? 1 : 0;
      v = (rd < rep_cnt) ? rep_pix[rd] : 0;
    end
    eo_hs = es_hs; eo_half = es_half;
    eo_vid = es_vid;
    es_hs = hs; es_half = h; es_vid = v;
    e_ovf = 0;
    if (lr) begin
      l = el + 1;
      if (l > 4095) l = 4095;
      rep_half = l / 2;
      rep_cnt = cur_q.size();
      foreach (cur_q[i]) rep_pix[i] = cur_q[i];
      cur_q.delete();
      ovf_done = 0;
      el = 0;
      if (nlr < 2) nlr++;
      started = (nlr >= 2);
      if (pc) cur_q.push_back(vid & 15);
    end else begin
      if (el < 100000) el++;
      if (pc) begin
        if (cur_q.size() < 1024)
          cur_q.push_back(vid & 15);
        else if (!ovf_done) begin
          e_ovf = 1;
          ovf_done = 1;
        end
      end
    end
    #1;
    check("hsync", int'(dbl_hsync), eo_hs);
    check("half", int'(dbl_half), eo_half);
    check("video", int'(dbl_video), eo_vid);
    check("ovf", int'(line_ovf), e_ovf);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_l = 1'b0;
    line_reset = 1'b0;
    pix_ce = 1'b0;
    #1;
    check("rst_hsync", int'(dbl_hsync), 0);
    check("rst_half", int'(dbl_half), 0);
    check("rst_video", int'(dbl_video), 0);
    check("rst_ovf", int'(line_ovf), 0);
    mdl_reset();
    repeat (3) @(posedge clk);
    #1 reset_l = 1'b1;
  endtask

  // mode 0 random, 1 every 2nd clk with
  // video = pixel index, 2 1100 strobes
  task automatic run_line(input int len,
                          input int mode,
                          input bit force_a);
    for (int i = 0; i < len; i++) begin
      bit pc;
      int v;
      case (mode)
        1: begin
          pc = (i % 2 == 0);
          v = i / 2;
        end
        2: begin
          pc = (i < 1100);
          v = int'($urandom_range(0, 15));
        end
        default: begin
          pc = ($urandom_range(0, 1) == 1);
          v = int'($urandom_range(0, 15));
        end
      endcase
      if (force_a && i == 0) begin
        pc = 1'b1;
        v = 10;
      end
      step(i == 0, pc, v);
    end
  endtask

  initial begin
    mdl_reset();
    do_reset();
    repeat (20) step(1'b0, 1'b0, 0);
    run_line(300, 0, 1'b0);
    run_line(912, 1, 1'b0);
    run_line(912, 0, 1'b0);
    run_line(300, 0, 1'b0);
    run_line(912, 0, 1'b0);
    run_line(1150, 2, 1'b0);
    run_line(1700, 0, 1'b1);
    run_line(600, 0, 1'b0);
    for (int k = 0; k < 4; k++)
      run_line(int'($urandom_range(100, 1000)),
               0, 1'b0);
    run_line(800, 0, 1'b0);
    run_line(600, 0, 1'b0);
    do_reset();
    repeat (10) step(1'b0, 1'b1, 5);
    run_line(200, 0, 1'b0);
    run_line(400, 1, 1'b0);
    run_line(400, 0, 1'b0);
    repeat (5) step(1'b0, 1'b0, 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errs);
    $finish;
  end

endmodule
